tick_timer_bank: RTL and testbench
==================================

# tick_timer_bank

Parametrised bank of millisecond countdown timers for the game datapath: a shared ms prescaler driving NCH independent channels, each one-shot or periodic. It replaces the fixed drop, down, bar and game-over tick constants with runtime-loadable timers. Each channel emits a one-cycle expire pulse to the main game FSM. A global pause freezes all timing, for example during clear or animation states.

## Interface
- MSEC_TICK, 25_000: clock cycles per millisecond; must be ≥ 2.
- NCH, 4: number of timer channels.
- CW, 16: width of every ms count.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sync  in  1  clears the prescaler to 0, aligning the ms grid.
- pause  in  1  global freeze of the prescaler and all channels.
- start  in  NCH  per-channel load-and-run strobe.
- stop  in  NCH  per-channel halt strobe.
- mode  in  NCH  sampled on start: 0 = one-shot, 1 = periodic.
- load_val  in  NCH*CW  channel i uses bits [i*CW +: CW]; value in ms, sampled on start.
- expire  out  NCH  one-cycle pulse on channel expiry.
- running  out  NCH  channel is counting.
- remain  out  NCH*CW  ms remaining per channel, same packing as load_val.

## Operation
Prescaler:
- pcnt counts 0..MSEC_TICK-1 and wraps to 0.
- ms_tick = (pcnt == MSEC_TICK-1) && !pause.
- pause holds pcnt. sync forces pcnt = 0 and takes priority over pause.

Per-channel registers: state {IDLE, RUN}, remain, period, pmode.

Per-channel priority, highest first:
1. start[i]
   - load_val ≠ 0: remain = period = load_val, pmode = mode[i], state = RUN.
   - load_val = 0: state = IDLE, remain = 0, expire[i] pulses (immediate expiry).
   - start wins over stop and over a same-cycle expiry. A restart suppresses that expiry pulse.
2. stop[i]: state = IDLE. remain holds its value frozen. No expire.
3. RUN && ms_tick
   - remain > 1: remain − 1.
   - remain == 1: expire[i] pulses.
     - pmode = 1: remain = period, stay in RUN.
     - pmode = 0: remain = 0, go to IDLE.
4. Otherwise: hold.

General rules:
- pause gates ms_tick only. start and stop still act while paused.
- Channels are fully independent. Any mix of simultaneous starts, stops and expiries across channels is legal.
- Arithmetic is unsigned CW-bit. remain never underflows and never exceeds period.
- running = (state == RUN).

## Timing
Reset values:
- pcnt = 0, all channels IDLE.
- remain = 0, period = 0, pmode = 0.
- expire = 0, running = 0.

Reset asserted mid-run clears everything immediately, asynchronously. No expire is emitted on or after reset release.

All outputs are registered and change one cycle after the causing edge:
- expire is high for exactly one cycle per expiry.
- running, remain and expire update on the same edge.

Expiry latency:
- If sync and start are on the same edge with load N, expire is high in the cycle exactly N*MSEC_TICK cycles after that edge.
- Without sync, the first decrement is at the next shared ms_tick. Duration is then in [(N−1)*MSEC_TICK+1, N*MSEC_TICK] cycles.
- Pause cycles add 1:1 to any duration.
- Periodic mode: successive expire pulses are exactly period*MSEC_TICK cycles apart when no pause occurs.

## Test plan
All scenarios use MSEC_TICK=4, NCH=2, CW=8.
- One-shot exact: sync + start[0], load 3, mode 0 at edge E0 → remain 2/1 after E4/E8. expire[0] high only in cycle after E12. running[0] falls with it and remain = 0.
- Periodic: sync + start[1], load 2, mode 1 → expire[1] pulses after E8, E16, E24. running stays 1 and remain reloads to 2 each time.
- Pause: one-shot load 2 with sync; pause held for 5 cycles starting after E2 → expire occurs 5 cycles later than 8, i.e. after E13. pcnt frozen at 2 during pause.
- Collision, and stop held until start:
  - ch0 remain=1, start[0] with load 5 on the ms_tick edge → no expire[0], remain = 5, running = 1.
  - stop[0] mid-count at remain=3 → running 0, remain 3 held, no expire thereafter.
- Zero load and independence: start[0] with load 0 → expire[0] one cycle, running[0] stays 0. Simultaneously start[1] with load 1 expires on its own ms_tick, unaffected.
- Reset mid-run: assert reset with ch0 at remain=2 periodic → all outputs 0 asynchronously. After release there is no expire until a new start.

Source files
------------

// File: rtl/tick_timer_bank_if.sv
// Control and status bundle between the game FSM and the ms timer bank.
// The game FSM drives the strobes and loads; the timer bank returns the status.
interface tick_timer_bank_if #(
  parameter int NCH = 4,
  parameter int CW  = 16
);
  logic              sync;
  logic              pause;
  logic [NCH-1:0]    start;
  logic [NCH-1:0]    stop;
  logic [NCH-1:0]    mode;
  logic [NCH*CW-1:0] load_val;
  logic [NCH-1:0]    expire;
  logic [NCH-1:0]    running;
  logic [NCH*CW-1:0] remain;

  modport master (
    output sync, pause, start, stop, mode, load_val,
    input  expire, running, remain
  );

  modport slave (
    input  sync, pause, start, stop, mode, load_val,
    output expire, running, remain
  );
endinterface

// File: rtl/tick_timer_bank.sv
// Bank of NCH runtime-loadable millisecond countdown timers sharing one prescaler.
// Each channel is one-shot or periodic and pulses expire for one cycle when it runs out.
module tick_timer_bank #(
  parameter int MSEC_TICK = 25_000,
  parameter int NCH       = 4,
  parameter int CW        = 16
) (
  input logic              clk,
  input logic              reset,
  tick_timer_bank_if.slave bus
);

  localparam int            PW    = $clog2(MSEC_TICK);
  localparam logic [PW-1:0] PLAST = PW'(MSEC_TICK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic           ms_tick;

  chan_state_e    state_q  [NCH];
  chan_state_e    state_d  [NCH];
  logic [CW-1:0]  remain_q [NCH];
  logic [CW-1:0]  remain_d [NCH];
  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [NCH-1:0] pmode_q, pmode_d;
  logic [NCH-1:0] expire_q, expire_d;

  // sync realigns the ms grid even while paused
  always_comb begin
    pcnt_d  = pcnt_q;
    ms_tick = (pcnt_q == PLAST) && !bus.pause;
    if (bus.sync) begin
      pcnt_d = '0;
    end else if (!bus.pause) begin
      pcnt_d = (pcnt_q == PLAST) ? '0 : pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  always_comb begin
    pmode_d  = pmode_q;
    expire_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      remain_d[i] = remain_q[i];
      period_d[i] = period_q[i];
      if (bus.start[i]) begin
        // a zero load expires at once instead of running for zero ms
        if (bus.load_val[i*CW +: CW] != '0) begin
          remain_d[i] = bus.load_val[i*CW +: CW];
          period_d[i] = bus.load_val[i*CW +: CW];
          pmode_d[i]  = bus.mode[i];
          state_d[i]  = RUN;
        end else begin
          remain_d[i] = '0;
          state_d[i]  = IDLE;
          expire_d[i] = 1'b1;
        end
      end else if (bus.stop[i]) begin
        state_d[i] = IDLE;
      end else if (state_q[i] == RUN && ms_tick) begin
        if (remain_q[i] > CW'(1)) begin
          remain_d[i] = remain_q[i] - CW'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (pmode_q[i]) begin
            remain_d[i] = period_q[i];
          end else begin
            remain_d[i] = '0;
            state_d[i]  = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pmode_q  <= '0;
      expire_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= IDLE;
        remain_q[i] <= '0;
        period_q[i] <= '0;
      end
    end else begin
      pmode_q  <= pmode_d;
      expire_q <= expire_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        remain_q[i] <= remain_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  always_comb begin
    bus.expire  = expire_q;
    bus.running = '0;
    bus.remain  = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.running[i]           = (state_q[i] == RUN);
      bus.remain[i*CW +: CW]   = remain_q[i];
    end
  end

endmodule

// File: tb/tb_tick_timer_bank.sv
// Bench for tick_timer_bank: directed scenarios with literal expectations, then random
// traffic, all shadowed by a deadline-based model checked every cycle.
module tb_tick_timer_bank;

  localparam int MSEC_TICK = 4;
  localparam int NCH       = 2;
  localparam int CW        = 8;

  logic clk;
  logic reset;

  tick_timer_bank_if #(.NCH(NCH), .CW(CW)) bus ();

  tick_timer_bank #(.MSEC_TICK(MSEC_TICK), .NCH(NCH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel expires when the global ms-tick count reaches its deadline.
  int m_pcnt  = 0;
  int m_ticks = 0;
  int m_dead   [NCH];
  int m_frozen [NCH];
  int m_period [NCH];
  bit m_run    [NCH];
  bit m_pmode  [NCH];
  bit m_expv   [NCH];

  function automatic void model_clear();
    m_pcnt  = 0;
    m_ticks = 0;
    for (int i = 0; i < NCH; i++) begin
      m_dead[i] = 0; m_frozen[i] = 0; m_period[i] = 0;
      m_run[i] = 0; m_pmode[i] = 0; m_expv[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit tick;
    int old_ticks;
    int ld;
    tick = (m_pcnt == MSEC_TICK - 1) && !bus.pause;
    if (bus.sync) m_pcnt = 0;
    else if (!bus.pause) m_pcnt = (m_pcnt + 1) % MSEC_TICK;
    old_ticks = m_ticks;
    if (tick) m_ticks++;
    for (int i = 0; i < NCH; i++) begin
      m_expv[i] = 0;
      ld = int'(bus.load_val[i*CW +: CW]);
      if (bus.start[i]) begin
        if (ld != 0) begin
          m_run[i] = 1; m_period[i] = ld; m_pmode[i] = bus.mode[i];
          m_dead[i] = m_ticks + ld;
        end else begin
          m_run[i] = 0; m_frozen[i] = 0; m_expv[i] = 1;
        end
      end else if (bus.stop[i]) begin
        if (m_run[i]) m_frozen[i] = m_dead[i] - old_ticks;
        m_run[i] = 0;
      end else if (m_run[i] && tick && m_ticks == m_dead[i]) begin
        m_expv[i] = 1;
        if (m_pmode[i]) m_dead[i] += m_period[i];
        else begin
          m_run[i] = 0; m_frozen[i] = 0;
        end
      end
    end
  endfunction

  // scoreboard compare, once per cycle just after the edge
  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else model_step();
    #1;
    for (int i = 0; i < NCH; i++) begin
      chk("model_expire", int'(bus.expire[i]), int'(m_expv[i]));
      chk("model_running", int'(bus.running[i]), int'(m_run[i]));
      chk("model_remain", int'(bus.remain[i*CW +: CW]),
          m_run[i] ? (m_dead[i] - m_ticks) : m_frozen[i]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic edge_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_strobes();
    bus.sync  = 1'b0;
    bus.start = '0;
    bus.stop  = '0;
  endtask

  task automatic arm(input int ch, input int ld, input bit md, input bit do_sync);
    bus.sync                  = do_sync;
    bus.start[ch]             = 1'b1;
    bus.load_val[ch*CW +: CW] = CW'(ld);
    bus.mode[ch]              = md;
  endtask

  function automatic int rem(input int ch);
    return int'(bus.remain[ch*CW +: CW]);
  endfunction

  initial begin
    reset        = 1'b1;
    bus.pause    = 1'b0;
    bus.mode     = '0;
    bus.load_val = '0;
    clear_strobes();
    edge_n(3);
    chk("rst_expire", int'(bus.expire), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_remain", int'(bus.remain), 0);
    #1 reset = 1'b0;
    edge_n(2);

    // one-shot exact timing
    arm(0, 3, 1'b0, 1'b1);
    edge_n(1); clear_strobes();
    chk("os_remain_e0", rem(0), 3);
    chk("os_running_e0", int'(bus.running[0]), 1);
    edge_n(4);  chk("os_remain_e4", rem(0), 2);
    edge_n(4);  chk("os_remain_e8", rem(0), 1);
    edge_n(3);  chk("os_noexp_e11", int'(bus.expire[0]), 0);
    edge_n(1);
    chk("os_expire_e12", int'(bus.expire[0]), 1);
    chk("os_running_e12", int'(bus.running[0]), 0);
    chk("os_remain_e12", rem(0), 0);
    edge_n(1);  chk("os_expire_e13", int'(bus.expire[0]), 0);

    // periodic
    arm(1, 2, 1'b1, 1'b1);
    edge_n(1); clear_strobes();
    for (int k = 1; k <= 24; k++) begin
      edge_n(1);
      chk("per_expire", int'(bus.expire[1]), (k % 8 == 0) ? 1 : 0);
      chk("per_running", int'(bus.running[1]), 1);
      if (k % 8 == 0) chk("per_reload", rem(1), 2);
    end

    // pause stretches the count
    arm(0, 2, 1'b0, 1'b1);
    edge_n(1); clear_strobes();
    edge_n(2);
    bus.pause = 1'b1;
    edge_n(5);
    bus.pause = 1'b0;
    chk("pause_remain_e7", rem(0), 2);
    edge_n(2);  chk("pause_remain_e9", rem(0), 1);
    edge_n(3);  chk("pause_noexp_e12", int'(bus.expire[0]), 0);
    edge_n(1);  chk("pause_expire_e13", int'(bus.expire[0]), 1);

    // restart on the expiring tick, then stop held
    arm(0, 1, 1'b0, 1'b1);
    edge_n(1); clear_strobes();
    edge_n(3);
    arm(0, 5, 1'b0, 1'b0);
    edge_n(1); clear_strobes();
    chk("coll_noexp", int'(bus.expire[0]), 0);
    chk("coll_remain", rem(0), 5);
    chk("coll_running", int'(bus.running[0]), 1);
    edge_n(8);  chk("stop_pre_remain", rem(0), 3);
    bus.stop[0] = 1'b1;
    edge_n(1);
    chk("stop_running", int'(bus.running[0]), 0);
    chk("stop_remain", rem(0), 3);
    for (int k = 0; k < 10; k++) begin
      edge_n(1);
      chk("stop_noexp", int'(bus.expire[0]), 0);
      chk("stop_hold", rem(0), 3);
    end
    arm(0, 2, 1'b0, 1'b0);
    edge_n(1); clear_strobes();
    chk("start_over_stop_run", int'(bus.running[0]), 1);
    chk("start_over_stop_rem", rem(0), 2);

    // zero load and independence
    arm(0, 0, 1'b0, 1'b1);
    arm(1, 1, 1'b0, 1'b1);
    edge_n(1); clear_strobes();
    chk("zero_expire", int'(bus.expire[0]), 1);
    chk("zero_running", int'(bus.running[0]), 0);
    chk("zero_remain", rem(0), 0);
    chk("ind_running", int'(bus.running[1]), 1);
    chk("ind_noexp", int'(bus.expire[1]), 0);
    edge_n(1);  chk("zero_once", int'(bus.expire[0]), 0);
    edge_n(3);
    chk("ind_expire", int'(bus.expire[1]), 1);
    chk("ind_done", int'(bus.running[1]), 0);

    // asynchronous reset mid-run
    arm(0, 2, 1'b1, 1'b1);
    edge_n(1); clear_strobes();
    edge_n(1);
    chk("prerst_remain", rem(0), 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_expire", int'(bus.expire), 0);
    chk("arst_running", int'(bus.running), 0);
    chk("arst_remain", int'(bus.remain), 0);
    edge_n(2);
    #3 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      edge_n(1);
      chk("postrst_noexp", int'(bus.expire), 0);
      chk("postrst_idle", int'(bus.running), 0);
    end

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bus.sync  = ($urandom_range(0, 15) == 0);
      bus.pause = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NCH; i++) begin
        bus.start[i]            = ($urandom_range(0, 9) == 0);
        bus.stop[i]             = ($urandom_range(0, 19) == 0);
        bus.mode[i]             = 1'($urandom_range(0, 1));
        bus.load_val[i*CW +: CW] = CW'($urandom_range(0, 6));
      end
      edge_n(1);
    end
    clear_strobes();
    bus.pause = 1'b0;
    edge_n(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
